// File: rtl/i2c_mailbox_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_mailbox_regs
// Purpose  : Register/mailbox stage behind the I2C peripheral protocol engine.
//            Bridges I2C register traffic to the core through two byte FIFOs
//            (I2C-to-core "i2c2c" and core-to-I2C "c2i"), and provides ID,
//            scratch, FIFO count and sticky status registers.
// Ports    : clk_i, rst_ni                 - clock, async active-low reset
//            i2c_reg_addr_i/_wdata_i       - register address / write data
//            i2c_reg_wrenable_i            - one-cycle write strobe
//            i2c_reg_rddata_o              - registered read data
//            i2c_reg_rd_byte_complete_i    - read byte shifted out (pops c2i)
//            c2i_data_i/_valid_i/_ready_o  - core push port of c2i FIFO
//            i2c2c_data_o/_valid_o/_ready_i- core pop port of i2c2c FIFO
//            scratch_o                     - scratch register value
//            irq_o                         - interrupt
// Options  : `define I2C_MAILBOX_IRQ_EN enables the registered interrupt
//            (i2c2c not empty | ovf | udf); otherwise irq_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_mailbox_regs #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] ID_VALUE   = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] i2c_reg_addr_i,
  input  logic [7:0] i2c_reg_wdata_i,
  input  logic       i2c_reg_wrenable_i,
  output logic [7:0] i2c_reg_rddata_o,
  input  logic       i2c_reg_rd_byte_complete_i,
  input  logic [7:0] c2i_data_i,
  input  logic       c2i_valid_i,
  output logic       c2i_ready_o,
  output logic [7:0] i2c2c_data_o,
  output logic       i2c2c_valid_o,
  input  logic       i2c2c_ready_i,
  output logic [7:0] scratch_o,
  output logic       irq_o
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

  localparam logic [7:0] c_addr_id      = 8'h00;
  localparam logic [7:0] c_addr_scratch = 8'h01;
  localparam logic [7:0] c_addr_i2c2c_d = 8'h10;
  localparam logic [7:0] c_addr_i2c2c_n = 8'h11;
  localparam logic [7:0] c_addr_c2i_d   = 8'h20;
  localparam logic [7:0] c_addr_c2i_n   = 8'h21;
  localparam logic [7:0] c_addr_status  = 8'h30;

  // FIFO storage and bookkeeping
  logic [7:0]         r_i2c2c_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_i2c2c_wptr, r_i2c2c_rptr;
  logic [c_cnt_w-1:0] r_i2c2c_cnt;
  logic [7:0]         r_c2i_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_c2i_wptr, r_c2i_rptr;
  logic [c_cnt_w-1:0] r_c2i_cnt;

  logic       r_ovf, r_udf;
  logic [7:0] r_scratch;
  logic [7:0] r_rddata;

  logic       w_i2c2c_full, w_i2c2c_empty, w_c2i_full, w_c2i_empty;
  logic       w_wr_i2c2c, w_i2c2c_push, w_i2c2c_pop, w_ovf_set;
  logic       w_rd_c2i, w_c2i_push, w_c2i_pop, w_udf_set;
  logic       w_status_wr, w_scratch_wr;
  logic [7:0] w_rddata;

  // Full/empty come from the pre-update count, so a push to a full FIFO is
  // dropped even when the other side pops in the same cycle.
  assign w_i2c2c_full  = (r_i2c2c_cnt == c_full_cnt);
  assign w_i2c2c_empty = (r_i2c2c_cnt == '0);
  assign w_c2i_full    = (r_c2i_cnt == c_full_cnt);
  assign w_c2i_empty   = (r_c2i_cnt == '0);

  assign w_wr_i2c2c   = i2c_reg_wrenable_i && (i2c_reg_addr_i == c_addr_i2c2c_d);
  assign w_i2c2c_push = w_wr_i2c2c && !w_i2c2c_full;
  assign w_ovf_set    = w_wr_i2c2c && w_i2c2c_full;
  assign w_i2c2c_pop  = !w_i2c2c_empty && i2c2c_ready_i;

  assign w_rd_c2i   = i2c_reg_rd_byte_complete_i && (i2c_reg_addr_i == c_addr_c2i_d);
  assign w_c2i_pop  = w_rd_c2i && !w_c2i_empty;
  assign w_udf_set  = w_rd_c2i && w_c2i_empty;
  assign w_c2i_push = c2i_valid_i && !w_c2i_full;

  assign w_status_wr  = i2c_reg_wrenable_i && (i2c_reg_addr_i == c_addr_status);
  assign w_scratch_wr = i2c_reg_wrenable_i && (i2c_reg_addr_i == c_addr_scratch);

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_i2c2c_fifo
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_i2c2c_mem[i] <= '0;
      r_i2c2c_wptr <= '0;
      r_i2c2c_rptr <= '0;
      r_i2c2c_cnt  <= '0;
    end else begin
      if (w_i2c2c_push) begin
        r_i2c2c_mem[r_i2c2c_wptr] <= i2c_reg_wdata_i;
        r_i2c2c_wptr              <= r_i2c2c_wptr + 1'b1;
      end
      if (w_i2c2c_pop) r_i2c2c_rptr <= r_i2c2c_rptr + 1'b1;
      case ({w_i2c2c_push, w_i2c2c_pop})
        2'b10:   r_i2c2c_cnt <= r_i2c2c_cnt + 1'b1;
        2'b01:   r_i2c2c_cnt <= r_i2c2c_cnt - 1'b1;
        default: r_i2c2c_cnt <= r_i2c2c_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_c2i_fifo
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_c2i_mem[i] <= '0;
      r_c2i_wptr <= '0;
      r_c2i_rptr <= '0;
      r_c2i_cnt  <= '0;
    end else begin
      if (w_c2i_push) begin
        r_c2i_mem[r_c2i_wptr] <= c2i_data_i;
        r_c2i_wptr            <= r_c2i_wptr + 1'b1;
      end
      if (w_c2i_pop) r_c2i_rptr <= r_c2i_rptr + 1'b1;
      case ({w_c2i_push, w_c2i_pop})
        2'b10:   r_c2i_cnt <= r_c2i_cnt + 1'b1;
        2'b01:   r_c2i_cnt <= r_c2i_cnt - 1'b1;
        default: r_c2i_cnt <= r_c2i_cnt;
      endcase
    end
  end

  // Sticky status: a set event in the same cycle as write-1-to-clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_status
    if (!rst_ni) begin
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_scratch <= '0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~(w_status_wr & i2c_reg_wdata_i[0]));
      r_udf <= w_udf_set | (r_udf & ~(w_status_wr & i2c_reg_wdata_i[1]));
      if (w_scratch_wr) r_scratch <= i2c_reg_wdata_i;
    end
  end

  always_comb begin : p_rd_mux
    w_rddata = 8'h00;
    case (i2c_reg_addr_i)
      c_addr_id:      w_rddata = ID_VALUE;
      c_addr_scratch: w_rddata = r_scratch;
      c_addr_i2c2c_n: w_rddata = 8'(r_i2c2c_cnt);
      c_addr_c2i_d:   w_rddata = w_c2i_empty ? 8'hFF : r_c2i_mem[r_c2i_rptr];
      c_addr_c2i_n:   w_rddata = 8'(r_c2i_cnt);
      c_addr_status:  w_rddata = {6'b0, r_udf, r_ovf};
      default:        w_rddata = 8'h00;
    endcase
  end

  // Reset value matches what the mux yields for the address held at 0 in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_rddata
    if (!rst_ni) r_rddata <= ID_VALUE;
    else         r_rddata <= w_rddata;
  end

  assign i2c_reg_rddata_o = r_rddata;
  assign c2i_ready_o      = !w_c2i_full;
  assign i2c2c_valid_o    = !w_i2c2c_empty;
  assign i2c2c_data_o     = r_i2c2c_mem[r_i2c2c_rptr];
  assign scratch_o        = r_scratch;

`ifdef I2C_MAILBOX_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_irq
    if (!rst_ni) r_irq <= 1'b0;
    else         r_irq <= !w_i2c2c_empty | r_ovf | r_udf;
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_mailbox_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_mailbox_regs
// Purpose  : Self-checking bench for i2c_mailbox_regs. Directed scenarios
//            followed by randomized traffic compared against a queue-based
//            reference model of the register map and FIFOs.
// Options  : honours `define I2C_MAILBOX_IRQ_EN for the expected irq_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_mailbox_regs;

  localparam int         FIFO_DEPTH = 8;
  localparam logic [7:0] ID_VALUE   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr, wdata, rddata, c2i_data, i2c2c_data, scratch;
  logic       wren, rd_done, c2i_valid, c2i_ready, i2c2c_valid, i2c2c_ready, irq;

  always #5 clk = ~clk;

  i2c_mailbox_regs #(.FIFO_DEPTH(FIFO_DEPTH), .ID_VALUE(ID_VALUE)) dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_n),
    .i2c_reg_addr_i             (addr),
    .i2c_reg_wdata_i            (wdata),
    .i2c_reg_wrenable_i         (wren),
    .i2c_reg_rddata_o           (rddata),
    .i2c_reg_rd_byte_complete_i (rd_done),
    .c2i_data_i                 (c2i_data),
    .c2i_valid_i                (c2i_valid),
    .c2i_ready_o                (c2i_ready),
    .i2c2c_data_o               (i2c2c_data),
    .i2c2c_valid_o              (i2c2c_valid),
    .i2c2c_ready_i              (i2c2c_ready),
    .scratch_o                  (scratch),
    .irq_o                      (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_i2c2c[$];
  logic [7:0] m_c2i[$];
  bit         m_ovf, m_udf, m_irq;
  logic [7:0] m_scratch, m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return ID_VALUE;
      8'h01:   return m_scratch;
      8'h11:   return 8'(m_i2c2c.size());
      8'h20:   return (m_c2i.size() == 0) ? 8'hFF : m_c2i[0];
      8'h21:   return 8'(m_c2i.size());
      8'h30:   return {6'b0, m_udf, m_ovf};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_i2c2c.delete();
    m_c2i.delete();
    m_ovf = 0; m_udf = 0; m_irq = 0;
    m_scratch = 8'h00;
    m_rd = ID_VALUE;
  endtask

  task automatic idle();
    wren = 0; rd_done = 0; c2i_valid = 0; i2c2c_ready = 0;
  endtask

  // One clock: predict from the pre-edge model, advance, then update model.
  task automatic cycle();
    logic [7:0] exp_rd, a, wd, cd;
    bit irq_next, i2c_full, c2i_empty, pop_i, push_c, rd_c, w, set_o, set_u;
    a = addr; wd = wdata; cd = c2i_data; w = wren;
    exp_rd    = model_read(a);
    irq_next  = (m_i2c2c.size() != 0) || m_ovf || m_udf;
    i2c_full  = (m_i2c2c.size() == FIFO_DEPTH);
    c2i_empty = (m_c2i.size() == 0);
    pop_i     = (m_i2c2c.size() != 0) && i2c2c_ready;
    push_c    = c2i_valid && (m_c2i.size() < FIFO_DEPTH);
    rd_c      = rd_done && (a == 8'h20);
    set_o     = 0; set_u = 0;
    @(posedge clk); #1;
    if (pop_i) void'(m_i2c2c.pop_front());
    if (w && a == 8'h10) begin
      if (i2c_full) set_o = 1;
      else m_i2c2c.push_back(wd);
    end
    if (rd_c) begin
      if (c2i_empty) set_u = 1;
      else void'(m_c2i.pop_front());
    end
    if (push_c) m_c2i.push_back(cd);
    if (w && a == 8'h30) begin
      if (wd[0]) m_ovf = 0;
      if (wd[1]) m_udf = 0;
    end
    if (set_o) m_ovf = 1;
    if (set_u) m_udf = 1;
    if (w && a == 8'h01) m_scratch = wd;
    m_rd = exp_rd;
`ifdef I2C_MAILBOX_IRQ_EN
    m_irq = irq_next;
`else
    m_irq = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rddata"}, rddata, m_rd);
    chk({tag, "_c2i_ready"}, c2i_ready, m_c2i.size() < FIFO_DEPTH);
    chk({tag, "_i2c2c_valid"}, i2c2c_valid, m_i2c2c.size() != 0);
    if (m_i2c2c.size() != 0) chk({tag, "_i2c2c_data"}, i2c2c_data, m_i2c2c[0]);
    chk({tag, "_scratch"}, scratch, m_scratch);
    chk({tag, "_irq"}, irq, m_irq);
  endtask

  initial begin
    logic [7:0] addrs [8];
    addrs = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h55};
    rst_n = 0; addr = 0; wdata = 0; c2i_data = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_rddata", rddata, 8'hA5);
    chk("rst_c2i_ready", c2i_ready, 1);
    chk("rst_i2c2c_valid", i2c2c_valid, 0);
    chk("rst_i2c2c_data", i2c2c_data, 8'h00);
    chk("rst_scratch", scratch, 8'h00);
    chk("rst_irq", irq, 0);
    rst_n = 1;

    // ID and counts
    addr = 8'h00; cycle(); chk("id", rddata, 8'hA5);
    addr = 8'h11; cycle(); chk("i2c2c_cnt0", rddata, 8'h00);
    addr = 8'h21; cycle(); chk("c2i_cnt0", rddata, 8'h00);

    // Scratch
    addr = 8'h01; wdata = 8'h3C; wren = 1; cycle();
    wren = 0; chk("scratch_out", scratch, 8'h3C);
    cycle(); chk("scratch_rd", rddata, 8'h3C);

    // Overflow of i2c2c then drain by core
    addr = 8'h10;
    for (int i = 1; i <= 9; i++) begin
      wdata = 8'(i); wren = 1; cycle();
    end
    wren = 0;
    addr = 8'h11; cycle(); chk("i2c2c_cnt_full", rddata, 8'h08);
    addr = 8'h30; cycle(); chk("status_ovf", rddata, 8'h01);
    i2c2c_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", i2c2c_valid, 1);
      chk("drain_data", i2c2c_data, 8'(i));
      cycle();
    end
    i2c2c_ready = 0;
    chk("drain_empty", i2c2c_valid, 0);

    // Core pushes, I2C pops on read
    c2i_valid = 1; c2i_data = 8'h11; cycle();
    c2i_data = 8'h22; cycle();
    c2i_valid = 0;
    addr = 8'h20; cycle(); chk("c2i_head0", rddata, 8'h11);
    rd_done = 1; cycle(); rd_done = 0; cycle(); chk("c2i_head1", rddata, 8'h22);
    rd_done = 1; cycle(); rd_done = 0; cycle(); chk("c2i_empty_ff", rddata, 8'hFF);
    rd_done = 1; cycle(); rd_done = 0;
    addr = 8'h30; cycle(); chk("status_udf", rddata, 8'h03);
    addr = 8'h21; cycle(); chk("c2i_cnt_udf", rddata, 8'h00);
    check_all("dir_a");

    // Write-1-to-clear
    addr = 8'h30; wdata = 8'h03; wren = 1; cycle();
    wren = 0; cycle(); chk("status_clr", rddata, 8'h00);
    // Re-overflow then clear only ovf
    addr = 8'h10; wren = 1;
    for (int i = 0; i < 9; i++) begin wdata = 8'(8'h40 + i); cycle(); end
    addr = 8'h30; wdata = 8'h01; cycle();
    wren = 0; cycle(); chk("status_clr_ovf", rddata, 8'h00);
    check_all("dir_b");

    // Asynchronous reset mid-traffic: i2c2c holds 8, trim to 5 by core pops
    i2c2c_ready = 1; repeat (3) cycle(); i2c2c_ready = 0;
    addr = 8'h11; cycle(); chk("pre_rst_cnt", rddata, 8'h05);
    c2i_valid = 1; c2i_data = 8'h77;
    #2 rst_n = 0; addr = 8'h00; idle();
    #1;
    chk("async_rst_valid", i2c2c_valid, 0);
    chk("async_rst_ready", c2i_ready, 1);
    chk("async_rst_rddata", rddata, 8'hA5);
    chk("async_rst_scratch", scratch, 8'h00);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    addr = 8'h11; cycle(); chk("post_rst_cnt", rddata, 8'h00);

    // irq after first push
    addr = 8'h10; wdata = 8'hE1; wren = 1; cycle(); wren = 0;
    chk("irq_same_cycle", irq, 0);
    cycle();
`ifdef I2C_MAILBOX_IRQ_EN
    chk("irq_after_push", irq, 1);
`else
    chk("irq_after_push", irq, 0);
`endif
    check_all("dir_c");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      addr        = addrs[$urandom_range(7)];
      wdata       = 8'($urandom);
      wren        = ($urandom_range(99) < 35);
      rd_done     = ($urandom_range(99) < 30);
      c2i_valid   = ($urandom_range(99) < 45);
      c2i_data    = 8'($urandom);
      i2c2c_ready = ($urandom_range(99) < 35);
      cycle();
      check_all("rand");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
